mask_bram_arbiter: RTL and testbench
====================================

// Module: mask_bram_arbiter
// PURPOSE
//  Owns the single-port 2D mask BRAM (1-cycle read latency) written by the mask grayscale stage.
//  Tracks mask frame completeness and arbitrates the port between that writer and two readers
//  (Hough/ROI stage, debug readback). Writer has absolute priority and is never stalled.
//  Reads are granted only once a complete mask frame is resident.
// PARAMETERS
//  WIDTH      720                     image width in pixels
//  HEIGHT     540                     image height in pixels
//  IMAGE_SIZE WIDTH*HEIGHT            pixels per mask frame
//  ADDR_W     $clog2(IMAGE_SIZE)      BRAM address width
// PORTS
//  clock        in   1       system clock
//  reset        in   1       reset, asynchronous, active-high
//  wr_en        in   1       writer strobe (no backpressure)
//  wr_addr      in   ADDR_W  writer address (y*WIDTH+x)
//  wr_data      in   8       writer grayscale pixel
//  rdN_req      in   1       reader N request, N=0,1; held until granted
//  rdN_addr     in   ADDR_W  reader N address
//  rdN_gnt      out  1       reader N granted this cycle (combinational)
//  rdN_valid    out  1       reader N data valid, 1 cycle after rdN_gnt
//  rdN_data     out  8       reader N data; 0 when rdN_valid=0
//  mask_clear   in   1       invalidate resident mask, restart frame count
//  mask_ready   out  1       complete mask frame resident (registered)
//  frame_done   out  1       1-cycle pulse, cycle after last pixel of frame written
//  bram_addr    out  ADDR_W  BRAM address (combinational)
//  bram_wr_en   out  1       BRAM write enable
//  bram_wr_data out  8       BRAM write data
//  bram_rd_data in   8       BRAM read data, valid 1 cycle after addr
// BEHAVIOUR
//  - Reset: state=LOADING, wr_cnt=0, rr_ptr favours rd0, all outputs 0; pending rdN_valid dropped.
//  - Port mux each cycle: wr_en -> write (bram_addr=wr_addr); else granted reader addr; else 0.
//  - LOADING: each wr_en increments wr_cnt; no read grants. wr_en with wr_cnt==IMAGE_SIZE-1
//    -> READY, wr_cnt=0, frame_done=1 and mask_ready=1 next cycle.
//  - READY: no wr_en -> one reader granted per arbitration. wr_en -> write performed, no read
//    grant that cycle, -> LOADING with wr_cnt=1; mask_ready=0 next cycle (new frame started).
//  - mask_clear (any state): -> LOADING, wr_cnt=0; with coincident wr_en the write is performed
//    and counted as first pixel (wr_cnt=1); no read grant that cycle.
//  - rdN_valid registered from rdN_gnt; rdN_data = bram_rd_data when rdN_valid, else 0.
//  - Back-to-back grants allowed every cycle; throughput 1 access/cycle.
//  - wr_cnt counts strobes only; wr_addr order unchecked.
//  - wr_cnt width ADDR_W; never exceeds IMAGE_SIZE-1.
// CONFIGURATION
//  MASK_ARB_ROUND_ROBIN_EN defined: reader arbitration round-robin; rr_ptr toggles to other
//    reader after each read grant; on contention reader != last granted wins; single requester
//    always wins.
//  Not defined: fixed priority, rd0 always beats rd1; rr_ptr absent.
// TESTING (WIDTH=4, HEIGHT=2, IMAGE_SIZE=8)
//  1. Reset, 8 writes addr 0..7 data=3*addr -> mask_ready=0 through 8th write, frame_done pulse
//     + mask_ready=1 the next cycle.
//  2. rd0_req addr 3 during LOADING -> rd0_gnt=0, rd0_valid=0; after ready: gnt same cycle,
//     rd0_valid=1, rd0_data=9 next cycle.
//  3. READY, rd0+rd1 held 4 cycles -> RR build: gnt 0,1,0,1; fixed build: rd0 x4, rd1 none.
//  4. READY, wr_en addr 0 data 0xAA with rd1_req -> bram_wr_en=1, rd1_gnt=0, mask_ready=0 next
//     cycle; 7 more writes -> ready again; rd1 addr 0 returns 0xAA.
//  5. READY, mask_clear with wr_en -> write performed, wr_cnt=1; 7 more writes -> frame_done.
//  6. Reset asserted cycle after rd1_gnt -> rd1_valid=0, mask_ready=0, state LOADING.

Source files
------------

// File: rtl/mask_bram_arbiter.sv
// Single-port mask BRAM owner: frame tracking plus writer/reader arbitration.
// Define MASK_ARB_ROUND_ROBIN_EN for round-robin readers; default is fixed rd0 priority.
module mask_bram_arbiter #(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int IMAGE_SIZE = WIDTH * HEIGHT,
  parameter int ADDR_W     = $clog2(IMAGE_SIZE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_gnt,
  output logic              rd0_valid,
  output logic [7:0]        rd0_data,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_gnt,
  output logic              rd1_valid,
  output logic [7:0]        rd1_data,
  input  logic              mask_clear,
  output logic              mask_ready,
  output logic              frame_done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_wr_en,
  output logic [7:0]        bram_wr_data,
  input  logic [7:0]        bram_rd_data
);

  typedef enum logic {
    LOADING,
    READY
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMAGE_SIZE - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] wr_cnt_nx;
  logic              done_nx;
  logic              can_rd;

`ifdef MASK_ARB_ROUND_ROBIN_EN
  // rr_ptr=1 means rd1 wins the next contention
  logic rr_ptr;
  logic rr_ptr_nx;
`endif

  always_comb begin
    state_nx  = state;
    wr_cnt_nx = wr_cnt;
    done_nx   = 1'b0;
    can_rd    = 1'b0;
    if (mask_clear) begin
      state_nx  = LOADING;
      wr_cnt_nx = wr_en ? ONE : '0;
    end else begin
      unique case (state)
        LOADING: begin
          if (wr_en) begin
            if (wr_cnt == LAST) begin
              state_nx  = READY;
              wr_cnt_nx = '0;
              done_nx   = 1'b1;
            end else begin
              wr_cnt_nx = wr_cnt + ONE;
            end
          end
        end
        READY: begin
          if (wr_en) begin
            state_nx  = LOADING;
            wr_cnt_nx = ONE;
          end else begin
            can_rd = 1'b1;
          end
        end
        default: state_nx = LOADING;
      endcase
    end
  end

`ifdef MASK_ARB_ROUND_ROBIN_EN
  always_comb begin
    rd0_gnt   = can_rd & rd0_req & (~rd1_req | ~rr_ptr);
    rd1_gnt   = can_rd & rd1_req & (~rd0_req | rr_ptr);
    rr_ptr_nx = rr_ptr;
    if (rd0_gnt) rr_ptr_nx = 1'b1;
    else if (rd1_gnt) rr_ptr_nx = 1'b0;
  end
`else
  always_comb begin
    rd0_gnt = can_rd & rd0_req;
    rd1_gnt = can_rd & rd1_req & ~rd0_req;
  end
`endif

  always_comb begin
    bram_addr = '0;
    unique case (1'b1)
      wr_en:   bram_addr = wr_addr;
      rd0_gnt: bram_addr = rd0_addr;
      rd1_gnt: bram_addr = rd1_addr;
      default: bram_addr = '0;
    endcase
  end

  assign bram_wr_en   = wr_en;
  assign bram_wr_data = wr_en ? wr_data : 8'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= LOADING;
      wr_cnt     <= '0;
      mask_ready <= 1'b0;
      frame_done <= 1'b0;
      rd0_valid  <= 1'b0;
      rd1_valid  <= 1'b0;
    end else begin
      state      <= state_nx;
      wr_cnt     <= wr_cnt_nx;
      mask_ready <= (state_nx == READY);
      frame_done <= done_nx;
      rd0_valid  <= rd0_gnt;
      rd1_valid  <= rd1_gnt;
    end
  end

`ifdef MASK_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_ptr <= 1'b0;
    else rr_ptr <= rr_ptr_nx;
  end
`endif

  assign rd0_data = rd0_valid ? bram_rd_data : 8'd0;
  assign rd1_data = rd1_valid ? bram_rd_data : 8'd0;

endmodule

// File: tb/tb_mask_bram_arbiter.sv
// Bench for mask_bram_arbiter: directed vector table, reset corner, then
// random traffic checked against a frame-level reference model.
module tb_mask_bram_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd0_req;
  logic [2:0] rd0_addr;
  logic       rd0_gnt;
  logic       rd0_valid;
  logic [7:0] rd0_data;
  logic       rd1_req;
  logic [2:0] rd1_addr;
  logic       rd1_gnt;
  logic       rd1_valid;
  logic [7:0] rd1_data;
  logic       mask_clear;
  logic       mask_ready;
  logic       frame_done;
  logic [2:0] bram_addr;
  logic       bram_wr_en;
  logic [7:0] bram_wr_data;
  logic [7:0] bram_rd_data;

  always #5 clock = ~clock;

  mask_bram_arbiter #(.WIDTH(4), .HEIGHT(2)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
    .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
    .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .mask_clear(mask_clear), .mask_ready(mask_ready),
    .frame_done(frame_done), .bram_addr(bram_addr),
    .bram_wr_en(bram_wr_en), .bram_wr_data(bram_wr_data),
    .bram_rd_data(bram_rd_data)
  );

  // Behavioural single-port BRAM, 1-cycle read latency
  logic [7:0] bram [0:7];
  always @(posedge clock) begin
    if (bram_wr_en) bram[bram_addr] <= bram_wr_data;
    bram_rd_data <= bram[bram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       r0;
    logic [2:0] a0;
    logic       r1;
    logic [2:0] a1;
    logic       clr;
    logic       eg0;
    logic       eg1;
    logic       erdy;
    logic       edone;
    logic [7:0] ed0;
    logic [7:0] ed1;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input int wr, input int wa, input int wd,
                              input int r0, input int a0, input int r1,
                              input int a1, input int clr, input int eg0,
                              input int eg1, input int erdy, input int edone,
                              input int ed0, input int ed1);
    vec_t v;
    v.wr = 1'(wr);   v.wa = 3'(wa);   v.wd = 8'(wd);
    v.r0 = 1'(r0);   v.a0 = 3'(a0);
    v.r1 = 1'(r1);   v.a1 = 3'(a1);   v.clr = 1'(clr);
    v.eg0 = 1'(eg0); v.eg1 = 1'(eg1);
    v.erdy = 1'(erdy); v.edone = 1'(edone);
    v.ed0 = 8'(ed0); v.ed1 = 8'(ed1);
    vq.push_back(v);
  endfunction

  task automatic drive(input logic wr, input logic [2:0] wa,
                       input logic [7:0] wd, input logic r0,
                       input logic [2:0] a0, input logic r1,
                       input logic [2:0] a1, input logic clr);
    wr_en = wr; wr_addr = wa; wr_data = wd;
    rd0_req = r0; rd0_addr = a0;
    rd1_req = r1; rd1_addr = a1;
    mask_clear = clr;
  endtask

  // Reference model: frame-level view of the mask
  logic [7:0] m_mem [0:7];
  int         m_cnt;
  bit         m_rdy;
  int         m_last;

  task automatic model_reset();
    m_cnt = 0; m_rdy = 0; m_last = 1;
  endtask

  task automatic mstep(input logic wr, input logic [2:0] wa,
                       input logic [7:0] wd, input logic r0,
                       input logic [2:0] a0, input logic r1,
                       input logic [2:0] a1, input logic clr);
    bit g0, g1, done, allow;
    logic [2:0] ea;
    logic [7:0] d0, d1;
    @(negedge clock);
    drive(wr, wa, wd, r0, a0, r1, a1, clr);
    allow = m_rdy && !wr && !clr;
    g0 = allow && r0;
    g1 = allow && r1 && !r0;
`ifdef MASK_ARB_ROUND_ROBIN_EN
    if (allow && r0 && r1) begin
      g0 = (m_last == 1);
      g1 = !g0;
    end
`endif
    ea = wr ? wa : g0 ? a0 : g1 ? a1 : 3'd0;
    #1;
    chk("rnd_gnt0", 32'(rd0_gnt), 32'(g0));
    chk("rnd_gnt1", 32'(rd1_gnt), 32'(g1));
    chk("rnd_wren", 32'(bram_wr_en), 32'(wr));
    chk("rnd_addr", 32'(bram_addr), 32'(ea));
    d0 = g0 ? m_mem[a0] : 8'd0;
    d1 = g1 ? m_mem[a1] : 8'd0;
    if (g0) m_last = 0;
    if (g1) m_last = 1;
    if (wr) m_mem[wa] = wd;
    done = 0;
    if (clr) begin
      m_cnt = wr ? 1 : 0;
      m_rdy = 0;
    end else if (wr) begin
      if (m_rdy) begin
        m_rdy = 0;
        m_cnt = 1;
      end else if (m_cnt == 7) begin
        m_rdy = 1;
        m_cnt = 0;
        done = 1;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clock);
    #1;
    chk("rnd_ready", 32'(mask_ready), 32'(m_rdy));
    chk("rnd_done", 32'(frame_done), 32'(done));
    chk("rnd_v0", 32'(rd0_valid), 32'(g0));
    chk("rnd_v1", 32'(rd1_valid), 32'(g1));
    chk("rnd_d0", 32'(rd0_data), 32'(d0));
    chk("rnd_d1", 32'(rd1_data), 32'(d1));
  endtask

  initial begin
    bit rr;
`ifdef MASK_ARB_ROUND_ROBIN_EN
    rr = 1;
`else
    rr = 0;
`endif
    for (int i = 0; i < 8; i++) bram[i] = 8'd0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Frame load with rd0 pending, then first read
    for (int i = 0; i < 8; i++)
      add(1, i, 3 * i, 1, 3, 0, 0, 0, 0, 0, i == 7, i == 7, 0, 0);
    add(0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 1, 0, 9, 0);
    add(0, 0, 0, 0, 0, 1, 5, 0, 0, 1, 1, 0, 0, 15);
    // Held contention for four cycles
    for (int k = 0; k < 4; k++) begin
      bit g0;
      g0 = rr ? (k % 2 == 0) : 1'b1;
      add(0, 0, 0, 1, 1, 1, 2, 0, g0, !g0, 1, 0, g0 ? 3 : 0, g0 ? 0 : 6);
    end
    // Writer preempts rd1 and starts a new frame
    add(1, 0, 8'hAA, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 8; i++)
      add(1, i, 3 * i, 0, 0, 0, 0, 0, 0, 0, i == 7, i == 7, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 8'hAA);
    // Clear with coincident write counts as first pixel
    add(1, 1, 8'h11, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i < 8; i++)
      add(1, i, 3 * i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 8'h55, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 1, 0, 8'h11, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 8'h55);
    // Bare clear in READY blocks reads and invalidates
    add(0, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    #12;
    chk("rst_ready", 32'(mask_ready), 32'(0));
    chk("rst_done", 32'(frame_done), 32'(0));
    chk("rst_v0", 32'(rd0_valid), 32'(0));
    chk("rst_v1", 32'(rd1_valid), 32'(0));
    chk("rst_d0", 32'(rd0_data), 32'(0));
    chk("rst_wren", 32'(bram_wr_en), 32'(0));
    chk("rst_addr", 32'(bram_addr), 32'(0));
    @(negedge clock);
    reset = 1'b0;

    foreach (vq[i]) begin
      vec_t v;
      logic [2:0] ea;
      v = vq[i];
      @(negedge clock);
      drive(v.wr, v.wa, v.wd, v.r0, v.a0, v.r1, v.a1, v.clr);
      ea = v.wr ? v.wa : v.eg0 ? v.a0 : v.eg1 ? v.a1 : 3'd0;
      #1;
      chk($sformatf("vec%0d_gnt0", i), 32'(rd0_gnt), 32'(v.eg0));
      chk($sformatf("vec%0d_gnt1", i), 32'(rd1_gnt), 32'(v.eg1));
      chk($sformatf("vec%0d_wren", i), 32'(bram_wr_en), 32'(v.wr));
      chk($sformatf("vec%0d_addr", i), 32'(bram_addr), 32'(ea));
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(mask_ready), 32'(v.erdy));
      chk($sformatf("vec%0d_done", i), 32'(frame_done), 32'(v.edone));
      chk($sformatf("vec%0d_v0", i), 32'(rd0_valid), 32'(v.eg0));
      chk($sformatf("vec%0d_v1", i), 32'(rd1_valid), 32'(v.eg1));
      chk($sformatf("vec%0d_d0", i), 32'(rd0_data), 32'(v.ed0));
      chk($sformatf("vec%0d_d1", i), 32'(rd1_data), 32'(v.ed1));
    end

    // Reset lands right after an rd1 grant
    @(negedge clock);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++)
      mstep(1, 3'(i), 8'(8'h40 + i), 0, 0, 0, 0, 0);
    mstep(0, 0, 0, 0, 0, 1, 3'd6, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_v1", 32'(rd1_valid), 32'(0));
    chk("arst_d1", 32'(rd1_data), 32'(0));
    chk("arst_ready", 32'(mask_ready), 32'(0));
    chk("arst_gnt1", 32'(rd1_gnt), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    mstep(0, 0, 0, 0, 0, 1, 3'd6, 0);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      logic wr, clr;
      clr = ($urandom_range(0, 49) == 0);
      wr  = m_rdy ? ($urandom_range(0, 9) == 0)
                  : ($urandom_range(0, 9) < 6);
      mstep(wr, 3'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
            1'($urandom), 3'($urandom), clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
